// File: rtl/dmem_responder.sv
// Data-memory responder: accepts one load/store per request, completes it LAT
// cycles later with a one-cycle done pulse, and flags rejected accesses with err.
module dmem_responder #(
  parameter int unsigned DEPTH = 64,
  parameter int unsigned LAT   = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mr,
  input  logic        mw,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        stall,
  output logic        done,
  output logic        err
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = 4;
  localparam int unsigned DW = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            rd_q, wr_q;
  logic [DW-1:0]   addr_q, wdata_q;
  logic [DW-1:0]   rdata_q, rdata_d;
  logic            done_q, done_d;
  logic            err_q, err_d;
  logic [DW-1:0]   mem_q [DEPTH];

  logic            req;
  logic            latch_en;
  logic            access_en;
  logic            mem_we;
  logic            acc_rd, acc_wr, acc_err;
  logic [DW-1:0]   acc_addr, acc_wdata;
  logic [AW-1:0]   acc_idx;

  assign req = mr | mw;

  // Access operands come straight from the inputs on an IDLE->DONE hop (LAT=1),
  // otherwise from the copy latched at acceptance.
  always_comb begin
    acc_rd    = rd_q;
    acc_wr    = wr_q;
    acc_addr  = addr_q;
    acc_wdata = wdata_q;
    if (state_q == IDLE) begin
      acc_rd    = mr;
      acc_wr    = mw;
      acc_addr  = addr;
      acc_wdata = wdata;
    end
  end

  assign acc_err = (acc_addr[1:0] != 2'b00) ||
                   (acc_addr >= DW'(4 * DEPTH)) ||
                   (acc_rd && acc_wr);
  assign acc_idx = acc_addr[AW+1:2];

  // Next-state logic; the counter holds the BUSY cycles still to go, so the
  // access fires on the cycle it would reach zero.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    latch_en  = 1'b0;
    access_en = 1'b0;
    case (state_q)
      IDLE: begin
        if (req) begin
          latch_en = 1'b1;
          cnt_d    = CW'(LAT - 1);
          if (LAT == 1) begin
            access_en = 1'b1;
            state_d   = DONE;
          end else begin
            state_d = BUSY;
          end
        end
      end
      BUSY: begin
        if (cnt_q <= CW'(1)) begin
          cnt_d     = '0;
          access_en = 1'b1;
          state_d   = DONE;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_comb begin
    rdata_d = rdata_q;
    done_d  = access_en;
    err_d   = access_en && acc_err;
    if (access_en && acc_rd && !acc_err) begin
      rdata_d = mem_q[acc_idx];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      done_q  <= done_d;
      err_q   <= err_d;
      if (latch_en) begin
        rd_q    <= mr;
        wr_q    <= mw;
        addr_q  <= addr;
        wdata_q <= wdata;
      end
    end
  end

  // Storage is not reset; writes are suppressed while reset is asserted.
  assign mem_we = rst_n && access_en && acc_wr && !acc_err;

  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[acc_idx] <= acc_wdata;
    end
  end

  assign stall = ((state_q == IDLE) && req) || (state_q == BUSY);
  assign rdata = rdata_q;
  assign done  = done_q;
  assign err   = err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: three instances (LAT 2, 4, 1) driven with directed
// and random accesses, checked against a word-array reference model.
module tb_dmem_responder;

  localparam int unsigned DEPTH = 64;

  logic        clk;
  logic        rst_n;
  logic        mr    [3];
  logic        mw    [3];
  logic [31:0] addr  [3];
  logic [31:0] wdata [3];
  logic [31:0] rdata [3];
  logic        stall [3];
  logic        done  [3];
  logic        err   [3];

  int checks   = 0;
  int failures = 0;
  int lat_of [3] = '{2, 4, 1};

  logic [31:0] mem_m    [3][DEPTH];
  bit          known_m  [3][DEPTH];
  logic [31:0] rd_m     [3];
  bit          rd_known [3];

  dmem_responder #(.DEPTH(DEPTH), .LAT(2)) u_lat2 (
    .clk(clk), .rst_n(rst_n), .mr(mr[0]), .mw(mw[0]), .addr(addr[0]), .wdata(wdata[0]),
    .rdata(rdata[0]), .stall(stall[0]), .done(done[0]), .err(err[0]));

  dmem_responder #(.DEPTH(DEPTH), .LAT(4)) u_lat4 (
    .clk(clk), .rst_n(rst_n), .mr(mr[1]), .mw(mw[1]), .addr(addr[1]), .wdata(wdata[1]),
    .rdata(rdata[1]), .stall(stall[1]), .done(done[1]), .err(err[1]));

  dmem_responder #(.DEPTH(DEPTH), .LAT(1)) u_lat1 (
    .clk(clk), .rst_n(rst_n), .mr(mr[2]), .mw(mw[2]), .addr(addr[2]), .wdata(wdata[2]),
    .rdata(rdata[2]), .stall(stall[2]), .done(done[2]), .err(err[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  function automatic bit model_err(input bit r, input bit w, input logic [31:0] a);
    return (a % 4 != 0) || (a >= 4 * DEPTH) || (r && w);
  endfunction

  // One complete access on instance k; entered and left just after a rising edge, DUT idle.
  task automatic do_access(input int k, input bit r, input bit w, input logic [31:0] a,
                           input logic [31:0] d, input bit scramble);
    bit e;
    int idx;
    e   = model_err(r, w, a);
    idx = int'(a / 4) % DEPTH;
    mr[k] = r; mw[k] = w; addr[k] = a; wdata[k] = d;
    @(negedge clk);
    check("stall_on_accept", 32'(stall[k]), 32'd1);
    check("no_early_done", 32'(done[k]), 32'd0);
    for (int c = 1; c < lat_of[k]; c++) begin
      @(posedge clk); #1;
      if (scramble) begin
        addr[k] = $urandom; wdata[k] = $urandom;
        mr[k] = 1'($urandom); mw[k] = 1'($urandom);
      end
      @(negedge clk);
      check("stall_busy", 32'(stall[k]), 32'd1);
      check("no_done_busy", 32'(done[k]), 32'd0);
    end
    @(posedge clk); #1;
    mr[k] = 1'b0; mw[k] = 1'b0;
    if (!e) begin
      if (w) begin
        mem_m[k][idx]   = d;
        known_m[k][idx] = 1'b1;
      end
      if (r) begin
        rd_m[k]     = mem_m[k][idx];
        rd_known[k] = known_m[k][idx];
      end
    end
    @(negedge clk);
    check("done_pulse", 32'(done[k]), 32'd1);
    check("err_flag", 32'(err[k]), 32'(e));
    check("stall_in_done", 32'(stall[k]), 32'd0);
    if (rd_known[k]) check("rdata_done", rdata[k], rd_m[k]);
    @(posedge clk); #1;
    @(negedge clk);
    check("done_clears", 32'(done[k]), 32'd0);
    check("err_clears", 32'(err[k]), 32'd0);
    if (rd_known[k]) check("rdata_hold", rdata[k], rd_m[k]);
    @(posedge clk); #1;
  endtask

  task automatic random_access(input int k);
    logic [31:0] a;
    bit r, w;
    int sel;
    case ($urandom_range(0, 9))
      0:       a = (32'($urandom_range(0, 15)) << 2) + 32'($urandom_range(1, 3));
      1:       a = 32'h100 + (32'($urandom_range(0, 1000)) << 2);
      default: a = 32'($urandom_range(0, 15)) << 2;
    endcase
    sel = int'($urandom_range(0, 9));
    r = (sel <= 4);
    w = (sel == 0) || (sel >= 5);
    do_access(k, r, w, a, $urandom, 1'b1);
  endtask

  initial begin
    for (int k = 0; k < 3; k++) begin
      mr[k] = 1'b0; mw[k] = 1'b0; addr[k] = '0; wdata[k] = '0;
      rd_m[k] = '0; rd_known[k] = 1'b1;
      for (int i = 0; i < DEPTH; i++) known_m[k][i] = 1'b0;
    end

    // Reset state, with a request pending on the LAT=2 instance to observe stall.
    rst_n = 1'b0;
    mr[0] = 1'b1;
    repeat (2) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      check("rst_rdata", rdata[k], 32'h0);
      check("rst_done", 32'(done[k]), 32'd0);
      check("rst_err", 32'(err[k]), 32'd0);
      check("rst_stall", 32'(stall[k]), 32'(k == 0));
    end
    mr[0] = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 3; k++) check("idle_stall", 32'(stall[k]), 32'd0);
    @(posedge clk); #1;

    // Directed store/load sequence on LAT=2.
    do_access(0, 1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 1'b0);
    do_access(0, 1'b1, 1'b0, 32'h10, 32'h0, 1'b0);
    check("load_back", rdata[0], 32'hDEADBEEF);
    do_access(0, 1'b1, 1'b0, 32'h12, 32'h0, 1'b0);
    check("misaligned_keeps_rdata", rdata[0], 32'hDEADBEEF);
    do_access(0, 1'b0, 1'b1, 32'h0, 32'h01020304, 1'b0);
    do_access(0, 1'b0, 1'b1, 32'h400, 32'hBADBAD00, 1'b0);
    do_access(0, 1'b1, 1'b0, 32'h0, 32'h0, 1'b0);
    check("oob_store_no_alias", rdata[0], 32'h01020304);
    do_access(0, 1'b0, 1'b1, 32'h20, 32'h55AA55AA, 1'b0);
    do_access(0, 1'b1, 1'b1, 32'h20, 32'h1234, 1'b0);
    do_access(0, 1'b1, 1'b0, 32'h20, 32'h0, 1'b0);
    check("both_req_no_write", rdata[0], 32'h55AA55AA);

    // Random traffic with inputs scrambled after acceptance.
    for (int n = 0; n < 60; n++) random_access(0);
    for (int n = 0; n < 20; n++) random_access(1);
    for (int n = 0; n < 20; n++) random_access(2);

    // Reset during BUSY on LAT=4 aborts the store.
    do_access(1, 1'b0, 1'b1, 32'h30, 32'h11112222, 1'b0);
    mr[1] = 1'b0; mw[1] = 1'b1; addr[1] = 32'h30; wdata[1] = 32'hA5A5A5A5;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    mw[1] = 1'b0;
    #1;
    check("abort_rdata_zero", rdata[1], 32'h0);
    check("abort_done_low", 32'(done[1]), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) rd_m[k] = '0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      check("abort_no_done", 32'(done[1]), 32'd0);
      check("abort_rdata", rdata[1], 32'h0);
    end
    @(posedge clk); #1;
    do_access(1, 1'b1, 1'b0, 32'h30, 32'h0, 1'b0);
    check("abort_word_intact", rdata[1], 32'h11112222);

    // Back-to-back reads with the request held on LAT=1.
    do_access(2, 1'b0, 1'b1, 32'h40, 32'hCAFEF00D, 1'b0);
    mr[2] = 1'b1; mw[2] = 1'b0; addr[2] = 32'h40;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("b2b_stall", 32'(stall[2]), 32'(i % 2 == 0));
      check("b2b_done", 32'(done[2]), 32'(i % 2 == 1));
      if (i % 2 == 1) check("b2b_rdata", rdata[2], 32'hCAFEF00D);
      @(posedge clk); #1;
    end
    mr[2] = 1'b0;
    @(negedge clk);
    check("b2b_idle", 32'(stall[2]), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 The block SHALL provide parameter DEPTH, default 64, giving the number of 32-bit data words held (power of two, 4..1024).
REQ-002 The block SHALL provide parameter LAT, default 2, giving the access latency in cycles from request to done (legal range 1..15).
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 mr  input  1  memory-read request from the control path (load).
REQ-006 mw  input  1  memory-write request from the control path (store).
REQ-007 addr  input  32  byte address from the ALU result.
REQ-008 wdata  input  32  store data (rs2 value).
REQ-009 rdata  output  32  load data, valid while done=1 for a read.
REQ-010 stall  output  1  core must hold the request and inputs stable while high.
REQ-011 done  output  1  one-cycle pulse marking completion of the accepted access.
REQ-012 err  output  1  qualifies done: access rejected and no memory effect.

Function
REQ-013 The block SHALL implement an FSM with states IDLE, BUSY and DONE.
REQ-014 In IDLE, when mr|mw=1, the block SHALL latch op, addr and wdata, load the wait counter with LAT-1, and move to BUSY. If LAT=1, it SHALL move directly to DONE.
REQ-015 In BUSY, the counter SHALL decrement each cycle. At counter=0, the block SHALL perform the access and move to DONE.
REQ-016 DONE SHALL last exactly one cycle, assert done=1, and return to IDLE. A request present in DONE SHALL NOT be accepted until IDLE.
REQ-017 Latency: request first seen in cycle t, done=1 in cycle t+LAT.
REQ-018 stall SHALL be combinational: 1 when (state=IDLE and (mr|mw)) or state=BUSY; 0 in DONE and in IDLE with no request.
REQ-019 The word index SHALL be addr[log2(DEPTH)+1:2]. Only 32-bit word accesses are supported.
REQ-020 A write SHALL update the indexed word with the latched wdata at the BUSY->DONE (or IDLE->DONE) transition. It SHALL NOT change rdata.
REQ-021 A read SHALL register the indexed word into rdata at the same transition. rdata SHALL hold that value until the next successful read.
REQ-022 err SHALL be set with done, and SHALL apply for any of the following conditions:
- misaligned request: latched addr[1:0] != 0
- out-of-range request: addr >= 4*DEPTH
- mr=1 and mw=1 together
REQ-023 On err, the block SHALL perform no memory write and leave rdata unchanged. err SHALL be 0 whenever done=0.
REQ-024 Changes to mr, mw, addr or wdata after acceptance SHALL be ignored until the next IDLE acceptance.

Reset
REQ-025 While rst_n=0, the block SHALL force state=IDLE, counter=0, rdata=32'h0, done=0 and err=0. stall SHALL then follow REQ-018.
REQ-026 Reset asserted mid-access (BUSY) SHALL abort the access: no memory write, and no done pulse after release.
REQ-027 Memory array contents SHALL NOT be reset. Their value is undefined until written.

Verification
REQ-028 LAT=2 store: mw=1, addr=0x10, wdata=0xDEADBEEF at cycle t -> stall=1 at t and t+1, done=1 and err=0 at t+2, stall=0 at t+2.
REQ-029 Load back: mr=1, addr=0x10 following REQ-028 -> rdata=0xDEADBEEF with done=1 at t+2. rdata holds 0xDEADBEEF through later idle cycles.
REQ-030 Misaligned load: mr=1, addr=0x12 -> done=1, err=1 at t+2, and rdata keeps its prior value. Bad store: mw=1, addr=0x400 (DEPTH=64) -> err=1, and a read of 0x000 is unchanged.
REQ-031 Both requests: mr=1, mw=1, addr=0x20, wdata=0x1234 -> err=1, and word 0x20 is unchanged on a subsequent read.
REQ-032 Reset abort: mw=1, addr=0x30, wdata=0xA5A5A5A5, LAT=4; assert rst_n=0 in BUSY cycle 2 -> done never pulses, rdata=0, and word 0x30 is not 0xA5A5A5A5.
REQ-033 Back-to-back: request held high continuously with LAT=1 -> done pulses every 2 cycles (accept, DONE, accept, ...), and stall toggles 1,0,1,0.
